// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the simulation run/verdict controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_RESET = 2'd0,
    RC_RUN   = 2'd1,
    RC_DONE  = 2'd2
  } rc_state_t;

  // tohost value that the core writes to report success
  localparam logic [31:0] TOHOST_PASS = 32'd1;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_run_controller_led_stable_det.sv
// Detects an LED pattern that has held for LED_STABLE consecutive cycles.
// hit is combinational on the cycle that completes the run so the verdict
// registers on the following edge, like a tohost write.
module led_stable_det
  import run_ctrl_pkg::*;
#(
  parameter int               LED_W      = 4,
  parameter int               LED_STABLE = 8,
  parameter logic [LED_W-1:0] PAT        = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LED_W-1:0] led,
  output logic             hit
);

  localparam int               RUN_W   = cnt_w(LED_STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LED_STABLE - 1);

  logic             match;
  logic [RUN_W-1:0] run_q, run_d;

  assign match = (led == PAT);
  assign hit   = en && match && (run_q == RUN_MAX);

  // Count earlier consecutive matching cycles; any mismatch or leaving RUN clears
  always_comb begin
    run_d = run_q;
    if (!en || !match) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // Run-length register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= '0;
    else      run_q <= run_d;
  end

endmodule

// File: rtl/sim_run_controller.sv
// Run/verdict controller: sequences core reset, counts run cycles and turns
// tohost writes, a stable LED pattern or a timeout into a sticky verdict.
//
// state    | meaning
// RC_RESET | core held in reset for RST_CYCLES cycles
// RC_RUN   | core running, monitors tohost/led, counts cycles
// RC_DONE  | verdict valid and frozen, core halted, waits for restart
module sim_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int               RST_CYCLES     = 4,
  parameter int               TIMEOUT_CYCLES = 1500,
  parameter int               LED_W          = 4,
  parameter int               LED_PASS_EN    = 0,
  parameter logic [LED_W-1:0] LED_PASS_PAT   = LED_W'('hF),
  parameter int               LED_STABLE     = 8,
  localparam int              CNT_W          = cnt_w(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [LED_W-1:0] led,
  input  logic             tohost_valid,
  input  logic [31:0]      tohost_data,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [15:0]      led_changes
);

  localparam int               RC_W    = cnt_w(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RST_MAX = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  rc_state_t        state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0]      led_changes_q, led_changes_d;
  logic [LED_W-1:0] led_prev_q, led_prev_d;
  logic             led_prev_vld_q, led_prev_vld_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_code_q, fail_code_d;

  logic det_hit, led_hit, th_term, th_fail;

  led_stable_det #(
    .LED_W      (LED_W),
    .LED_STABLE (LED_STABLE),
    .PAT        (LED_PASS_PAT)
  ) u_led_det (
    .clk (clk),
    .rst (rst),
    .en  (state_q == RC_RUN),
    .led (led),
    .hit (det_hit)
  );

  assign led_hit = (LED_PASS_EN != 0) && det_hit;
  assign th_term = tohost_valid && tohost_data[0];
  assign th_fail = th_term && (tohost_data != TOHOST_PASS);

  // Next-state, counter and verdict logic; priority fail > pass > LED > timeout
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    led_changes_d  = led_changes_q;
    led_prev_d     = led_prev_q;
    led_prev_vld_d = led_prev_vld_q;
    core_rst_d     = core_rst_q;
    running_d      = running_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    fail_code_d    = fail_code_q;
    case (state_q)
      RC_RESET: begin
        core_rst_d = 1'b1;
        if (rst_cnt_q == RST_MAX) begin
          state_d     = RC_RUN;
          rst_cnt_d   = '0;
          core_rst_d  = 1'b0;
          running_d   = 1'b1;
          cycle_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      RC_RUN: begin
        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        led_prev_d     = led;
        led_prev_vld_d = 1'b1;
        if (led_prev_vld_q && (led != led_prev_q) && (led_changes_q != 16'hFFFF))
          led_changes_d = led_changes_q + 16'd1;
        if (th_fail || th_term || led_hit || (cycle_cnt_q == CNT_MAX)) begin
          state_d    = RC_DONE;
          core_rst_d = 1'b1;
          running_d  = 1'b0;
          done_d     = 1'b1;
          if (th_fail) begin
            pass_d      = 1'b0;
            fail_code_d = tohost_data[31:1];
          end else if (th_term || led_hit) begin
            pass_d = 1'b1;
          end else begin
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      RC_DONE: begin
        core_rst_d = 1'b1;
        if (restart) begin
          state_d        = RC_RESET;
          rst_cnt_d      = '0;
          cycle_cnt_d    = '0;
          led_changes_d  = '0;
          led_prev_d     = '0;
          led_prev_vld_d = 1'b0;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          timeout_d      = 1'b0;
          fail_code_d    = '0;
        end
      end
      default: begin
        state_d    = RC_RESET;
        rst_cnt_d  = '0;
        core_rst_d = 1'b1;
        running_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RC_RESET;
      rst_cnt_q      <= '0;
      cycle_cnt_q    <= '0;
      led_changes_q  <= '0;
      led_prev_q     <= '0;
      led_prev_vld_q <= 1'b0;
      core_rst_q     <= 1'b1;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      fail_code_q    <= '0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
      led_changes_q  <= led_changes_d;
      led_prev_q     <= led_prev_d;
      led_prev_vld_q <= led_prev_vld_d;
      core_rst_q     <= core_rst_d;
      running_q      <= running_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      fail_code_q    <= fail_code_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign led_changes = led_changes_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller (RST 4, timeout 50, LED pass F x8).
module tb_sim_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic [3:0]  led;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        core_rst, running, done, pass, timeout;
  logic [30:0] fail_code;
  logic [5:0]  cycle_cnt;
  logic [15:0] led_changes;

  int n_chk  = 0;
  int n_pass = 0;

  sim_run_controller #(
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (50),
    .LED_W          (4),
    .LED_PASS_EN    (1),
    .LED_PASS_PAT   (4'hF),
    .LED_STABLE     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .led          (led),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data),
    .core_rst     (core_rst),
    .running      (running),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .fail_code    (fail_code),
    .cycle_cnt    (cycle_cnt),
    .led_changes  (led_changes)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_verdict(input string tag, input logic d, input logic p, input logic t,
                             input logic [30:0] fc, input logic [5:0] cc);
    chk({tag, " done"}, {31'd0, done}, {31'd0, d});
    chk({tag, " pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, t});
    chk({tag, " fail_code"}, {1'b0, fail_code}, {1'b0, fc});
    chk({tag, " cycle_cnt"}, {26'd0, cycle_cnt}, {26'd0, cc});
  endtask

  // From DONE: pulse restart, check cleared state, wait out the 4 reset cycles
  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_verdict({tag, " cleared"}, 1'b0, 1'b0, 1'b0, 31'd0, 6'd0);
    chk({tag, " led_changes cleared"}, {16'd0, led_changes}, 32'd0);
    chk({tag, " core_rst in reset"}, {31'd0, core_rst}, 32'd1);
    tick(3);
    chk({tag, " still in reset"}, {31'd0, running}, 32'd0);
    tick();
    chk({tag, " running"}, {31'd0, running}, 32'd1);
    chk({tag, " core_rst released"}, {31'd0, core_rst}, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    restart      = 1'b0;
    led          = 4'h0;
    tohost_valid = 1'b0;
    tohost_data  = 32'd0;

    // reset values and reset sequencing
    tick(3);
    chk_verdict("reset", 1'b0, 1'b0, 1'b0, 31'd0, 6'd0);
    chk("reset core_rst", {31'd0, core_rst}, 32'd1);
    chk("reset running", {31'd0, running}, 32'd0);
    chk("reset led_changes", {16'd0, led_changes}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst seq core_rst c%0d", i + 1), {31'd0, core_rst}, 32'd1);
      tick();
    end
    chk("c5 running", {31'd0, running}, 32'd1);
    chk("c5 core_rst", {31'd0, core_rst}, 32'd0);
    chk("c5 cycle_cnt", {26'd0, cycle_cnt}, 32'd0);

    // tohost pass at cycle_cnt 20
    tick(20);
    chk("pre-pass cycle_cnt", {26'd0, cycle_cnt}, 32'd20);
    tohost_valid = 1'b1;
    tohost_data  = 32'd1;
    tick();
    tohost_valid = 1'b0;
    chk_verdict("tohost pass", 1'b1, 1'b1, 1'b0, 31'd0, 6'd21);
    chk("tohost pass core_rst", {31'd0, core_rst}, 32'd1);
    chk("tohost pass running", {31'd0, running}, 32'd0);
    tohost_valid = 1'b1;
    tohost_data  = 32'd3;
    led          = 4'h5;
    tick(3);
    tohost_valid = 1'b0;
    led          = 4'h0;
    chk_verdict("done frozen", 1'b1, 1'b1, 1'b0, 31'd0, 6'd21);
    chk("done frozen led_changes", {16'd0, led_changes}, 32'd0);

    // tohost fail, with an ignored even write and an ignored restart in RUN
    do_restart("restart1");
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart in RUN ignored", {31'd0, running}, 32'd1);
    chk("restart in RUN cycle_cnt", {26'd0, cycle_cnt}, 32'd1);
    tick(4);
    tohost_valid = 1'b1;
    tohost_data  = 32'h40;
    tick();
    chk_verdict("even write ignored", 1'b0, 1'b0, 1'b0, 31'd0, 6'd6);
    tohost_data = 32'h7;
    tick();
    tohost_valid = 1'b0;
    chk_verdict("tohost fail", 1'b1, 1'b0, 1'b0, 31'd3, 6'd7);

    // timeout
    do_restart("restart2");
    tick(49);
    chk_verdict("pre-timeout", 1'b0, 1'b0, 1'b0, 31'd0, 6'd49);
    tick();
    chk_verdict("timeout", 1'b1, 1'b0, 1'b1, 31'd0, 6'd49);

    // tohost pass beats timeout on the last cycle
    do_restart("restart3");
    tick(49);
    tohost_valid = 1'b1;
    tohost_data  = 32'd1;
    tick();
    tohost_valid = 1'b0;
    chk_verdict("pass beats timeout", 1'b1, 1'b1, 1'b0, 31'd0, 6'd49);

    // LED pass: 7 cycles of F is not enough, 8 is
    do_restart("restart4");
    tick();
    led = 4'hF;
    tick(7);
    led = 4'h0;
    tick(3);
    chk("led 7-run no verdict", {31'd0, done}, 32'd0);
    chk("led changes after 7-run", {16'd0, led_changes}, 32'd2);
    led = 4'hF;
    tick(7);
    chk("led 7 of 8 no verdict", {31'd0, done}, 32'd0);
    tick();
    chk_verdict("led pass", 1'b1, 1'b1, 1'b0, 31'd0, 6'd19);
    chk("led pass led_changes", {16'd0, led_changes}, 32'd3);

    // tohost fail beats a simultaneous LED pass
    do_restart("restart5");
    tick(7);
    tohost_valid = 1'b1;
    tohost_data  = 32'h5;
    tick();
    tohost_valid = 1'b0;
    chk_verdict("fail beats led", 1'b1, 1'b0, 1'b0, 31'd2, 6'd8);
    chk("constant led no changes", {16'd0, led_changes}, 32'd0);

    // async reset mid-RUN
    led = 4'h0;
    do_restart("restart6");
    led = 4'h3;
    tick(5);
    rst = 1'b0;
    #2;
    chk_verdict("async rst", 1'b0, 1'b0, 1'b0, 31'd0, 6'd0);
    chk("async rst core_rst", {31'd0, core_rst}, 32'd1);
    chk("async rst running", {31'd0, running}, 32'd0);
    chk("async rst led_changes", {16'd0, led_changes}, 32'd0);
    tick();
    rst = 1'b1;
    tick(3);
    chk("post-rst still reset", {31'd0, running}, 32'd0);
    tick();
    chk("post-rst running", {31'd0, running}, 32'd1);
    tick(2);
    tohost_valid = 1'b1;
    tohost_data  = 32'd1;
    tick();
    tohost_valid = 1'b0;
    chk_verdict("post-rst pass", 1'b1, 1'b1, 1'b0, 31'd0, 6'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
